traffic_light_param: RTL
========================

TRAFFIC_LIGHT_PARAM -- requirements
Module: traffic_light_param

Interface
REQ-001 Parameter GREEN_T, default 6, green phase minimum duration in clk cycles (>=1).
REQ-002 Parameter YELLOW_T, default 1, yellow phase duration in clk cycles (>=1).
REQ-003 Parameter ALLRED_T, default 1, all-red clearance duration in clk cycles (>=1).
REQ-004 Parameter FLASH_T, default 2, flash-mode half-period in clk cycles (>=1).
REQ-005 Parameter CW, default 4, timer width; every duration parameter SHALL be <= 2^CW.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-low.
REQ-008 req_A  input  1  vehicle demand on road A; level-sensitive.
REQ-009 req_B  input  1  vehicle demand on road B; level-sensitive.
REQ-010 flash_en  input  1  night/fault flashing-mode request; level-sensitive.
REQ-011 light_A  output  3  road A lamp, one-hot {green,yellow,red} = {100,010,001}; 000 = dark.
REQ-012 light_B  output  3  road B lamp, same encoding.
REQ-013 phase  output  3  current state code (S0..S5 = 0..5, FLASH = 6).

Function
REQ-014 States, lamps (A/B): S0 red/green, S1 red/yellow, S2 red/red, S3 green/red, S4 yellow/red, S5 red/red, FLASH per REQ-022.
REQ-015 light_A, light_B, phase SHALL decode combinationally from the registered state only; no input-to-output combinational path.
REQ-016 Single down-counter timer (CW bits); on every state entry it SHALL load (duration-1) for the entered state; decrements each cycle while nonzero.
REQ-017 Expiry = timer==0; a state with duration N SHALL occupy exactly N cycles when its exit condition is true at expiry.
REQ-018 S0 -> S1 at expiry only if req_A=1; else hold S0, timer held at 0, transition on first cycle req_A=1.
REQ-019 S3 -> S4 at expiry only if req_B=1; else hold S3 same as REQ-018.
REQ-020 S1 -> S2, S2 -> S3, S4 -> S5, S5 -> S0 unconditionally at expiry, except REQ-021.
REQ-021 At expiry of S2 or S5, flash_en=1 SHALL take FLASH instead; flash_en is ignored in all other states (no green/yellow truncation).
REQ-022 FLASH: internal blink bit set to 1 on entry, toggles every FLASH_T cycles; light_A = yellow when blink=1 else 000; light_B = red when blink=1 else 000.
REQ-023 FLASH exit: first cycle flash_en=0 -> S5 (full ALLRED_T), then S0 per REQ-020.
REQ-024 Simultaneous req_A and req_B: no priority effect; fixed rotation S0..S5 holds.
REQ-025 Timer SHALL never wrap below 0; no state SHALL show green on both roads or green with yellow on the other road.

Reset
REQ-026 rst=0 sampled at a clk edge SHALL force state S0, timer GREEN_T-1, blink 0, regardless of current state (including FLASH or mid-phase).
REQ-027 During and immediately after reset: light_A=001, light_B=100, phase=0; first timed cycle is the cycle after rst returns to 1.
REQ-028 No initial blocks; all registers reset only via rst.

Verification
REQ-029 Defaults, req_A=req_B=1, flash_en=0 after reset -> phase sequence 0x6,1x1,2x1,3x6,4x1,5x1, period 16 cycles, repeating.
REQ-030 req_A=0 after reset -> phase stays 0 beyond cycle 6; assert req_A at cycle 20 -> phase=1 at cycle 21, phase=2 at cycle 22.
REQ-031 flash_en=1 asserted in S3 -> S3/S4 complete normally, S5 one cycle, then phase=6, light_A 010,000,010,... each held 2 cycles, light_B 001/000 in step.
REQ-032 flash_en dropped while in FLASH -> next cycle phase=5 (light_A=light_B=001) for 1 cycle, then phase=0.
REQ-033 rst=0 for one cycle during S3 cycle 3, then in FLASH -> each time next cycle phase=0, light_A=001, light_B=100, full 6-cycle S0 follows.
REQ-034 Parameter sweep GREEN_T=1, YELLOW_T=3, ALLRED_T=2, CW=2 -> per-state durations match parameters exactly; assertion REQ-025 never fires.

Source files
------------

// File: rtl/traffic_light_param_if.sv
// Signal bundle for the two-road traffic controller: demand/flash inputs in,
// lamp and phase outputs back. The controller uses the slave modport.
interface traffic_light_param_if;
   logic       req_A;
   logic       req_B;
   logic       flash_en;
   logic [2:0] light_A;
   logic [2:0] light_B;
   logic [2:0] phase;

   modport master (
      output req_A, req_B, flash_en,
      input  light_A, light_B, phase
   );

   modport slave (
      input  req_A, req_B, flash_en,
      output light_A, light_B, phase
   );
endinterface

// File: rtl/traffic_light_param.sv
// Two-road traffic light controller with demand-held greens, all-red clearance
// and a flashing night/fault mode. Lamps and phase decode from registered state only.
module traffic_light_param #(
   parameter int GREEN_T  = 6,
   parameter int YELLOW_T = 1,
   parameter int ALLRED_T = 1,
   parameter int FLASH_T  = 2,
   parameter int CW       = 4
) (
   input  logic clk,
   input  logic rst,
   traffic_light_param_if.slave bus
);

   typedef enum logic [2:0] {
      S0    = 3'd0,
      S1    = 3'd1,
      S2    = 3'd2,
      S3    = 3'd3,
      S4    = 3'd4,
      S5    = 3'd5,
      FLASH = 3'd6
   } state_t;

   localparam logic [2:0] LAMP_G = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_R = 3'b001;
   localparam logic [2:0] LAMP_D = 3'b000;

   localparam logic [CW-1:0] G_LD = CW'(GREEN_T - 1);
   localparam logic [CW-1:0] Y_LD = CW'(YELLOW_T - 1);
   localparam logic [CW-1:0] A_LD = CW'(ALLRED_T - 1);
   localparam logic [CW-1:0] F_LD = CW'(FLASH_T - 1);

   state_t        state, state_n;
   logic [CW-1:0] timer, timer_n;
   logic          blink, blink_n;
   logic          expired;
   logic          conflict;

   function automatic logic [CW-1:0] load_for(input state_t s);
      case (s)
         S0, S3:  load_for = G_LD;
         S1, S4:  load_for = Y_LD;
         S2, S5:  load_for = A_LD;
         FLASH:   load_for = F_LD;
         default: load_for = G_LD;
      endcase
   endfunction

   assign expired = (timer == '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S0;
         timer <= G_LD;
         blink <= 1'b0;
      end else begin
         state <= state_n;
         timer <= timer_n;
         blink <= blink_n;
      end
   end

   always_comb begin
      state_n = state;
      timer_n = expired ? '0 : timer - CW'(1);
      blink_n = blink;
      case (state)
         S0:      if (expired && bus.req_A) state_n = S1;
         S1:      if (expired) state_n = S2;
         S2:      if (expired) state_n = bus.flash_en ? FLASH : S3;
         S3:      if (expired && bus.req_B) state_n = S4;
         S4:      if (expired) state_n = S5;
         S5:      if (expired) state_n = bus.flash_en ? FLASH : S0;
         FLASH:   if (!bus.flash_en) state_n = S5;
         default: state_n = S0;
      endcase
      // Every entry reloads the timer; blink restarts lit when entering FLASH.
      if (state_n != state) begin
         timer_n = load_for(state_n);
         blink_n = (state_n == FLASH);
      end else if (state == FLASH && expired) begin
         timer_n = F_LD;
         blink_n = ~blink;
      end
   end

   always_comb begin
      bus.light_A = LAMP_R;
      bus.light_B = LAMP_R;
      bus.phase   = state;
      case (state)
         S0:      bus.light_B = LAMP_G;
         S1:      bus.light_B = LAMP_Y;
         S3:      bus.light_A = LAMP_G;
         S4:      bus.light_A = LAMP_Y;
         FLASH: begin
            bus.light_A = blink ? LAMP_Y : LAMP_D;
            bus.light_B = blink ? LAMP_R : LAMP_D;
         end
         default: ;
      endcase
   end

   // A green on one road must never coexist with green or yellow on the other.
   assign conflict = (bus.light_A[2] && (bus.light_B[2] || bus.light_B[1])) ||
                     (bus.light_B[2] && (bus.light_A[2] || bus.light_A[1]));

   no_conflicting_lamps: assert property (@(posedge clk) !conflict);

endmodule
